// File: rtl/sqrt_scheduler_if.sv
// Request/response bus of the square-root scheduler: per-requester radicand
// handshake on the way in, result FIFO head on the way out.
interface sqrt_scheduler_if #(
  parameter int DATAWIDTH = 32,
  parameter int NUM_REQ   = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DATAWIDTH-1:0] req_radicand;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [IDW-1:0]               rsp_id;
  logic [DATAWIDTH-1:0]         rsp_root;
  logic [DATAWIDTH-1:0]         rsp_remainder;

  modport master (
    output req_valid, req_radicand, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_root, rsp_remainder
  );

  modport slave (
    input  req_valid, req_radicand, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_root, rsp_remainder
  );
endinterface

// File: rtl/sqrt_scheduler.sv
// Round-robin front end sharing one fixed-latency square_root pipeline between
// NUM_REQ requesters, with an ID tag line and a credit-protected result FIFO.
module sqrt_scheduler #(
  parameter int DATAWIDTH  = 32,
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sqrt_scheduler_if.slave      bus,
  output logic                 sq_i_valid,
  output logic [DATAWIDTH-1:0] sq_radicand,
  input  logic                 sq_o_valid,
  input  logic [DATAWIDTH-1:0] sq_root,
  input  logic [DATAWIDTH-1:0] sq_remainder,
  input  logic                 flush,
  output logic                 flush_done,
  output logic [1:0]           err
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int GW  = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;

  typedef struct packed {
    logic [IDW-1:0]       id;
    logic [DATAWIDTH-1:0] root;
    logic [DATAWIDTH-1:0] rem;
  } rsp_t;

  state_t                          state_q, state_d;
  logic [GW-1:0]                   guard_cnt;
  logic                            guard_done;
  logic [CW-1:0]                   outstanding;
  logic [IDW-1:0]                  rr_ptr, next_ptr, grant_id;
  logic [NUM_REQ-1:0]              grant;
  logic                            found, issue_legal, issue;
  logic [LATENCY-1:0]              tag_v;
  logic [LATENCY-1:0][IDW-1:0]     tag_id;
  logic                            push, pop, spur, miss;
  rsp_t                            mem [FIFO_DEPTH];
  rsp_t                            head;
  logic [PW-1:0]                   wr_ptr, rd_ptr;
  logic [CW-1:0]                   count;
  logic                            rsp_valid;
  logic [1:0]                      err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The datapath has no reset, so anything it emits right after reset is garbage.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 guard_cnt <= GW'(LATENCY);
    else if (!guard_done)      guard_cnt <= guard_cnt - GW'(1);
  end
  assign guard_done  = (guard_cnt == '0);
  assign issue_legal = guard_done && (outstanding < DEPTH_C) && (state_q == RUN) && !flush;

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    int idx;
    grant       = '0;
    grant_id    = '0;
    next_ptr    = rr_ptr;
    sq_radicand = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && issue_legal && bus.req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IDW'(idx);
        sq_radicand = bus.req_radicand[idx*DATAWIDTH +: DATAWIDTH];
        next_ptr    = (idx == NUM_REQ - 1) ? '0 : IDW'(idx + 1);
      end
    end
  end

  assign bus.req_ready = grant;
  assign sq_i_valid    = |(bus.req_valid & grant);
  assign issue         = sq_i_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      rr_ptr <= '0;
    else if (issue) rr_ptr <= next_ptr;
  end

  // Tag line mirrors the datapath so each result knows its owner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[LATENCY-2:0], issue};
      tag_id <= {tag_id[LATENCY-2:0], grant_id};
    end
  end

  assign push = guard_done &  sq_o_valid &  tag_v[LATENCY-1];
  assign spur = guard_done &  sq_o_valid & ~tag_v[LATENCY-1];
  assign miss = guard_done & ~sq_o_valid &  tag_v[LATENCY-1];
  assign pop  = rsp_valid & bus.rsp_ready;

  // A missing result still returns its credit so the scheduler cannot starve.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outstanding <= '0;
      err_q       <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(pop) - CW'(miss);
      err_q       <= err_q | {miss, spur};
    end
  end
  assign err = err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is left unreset; the pointers and count alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= '{id: tag_id[LATENCY-1], root: sq_root, rem: sq_remainder};
  end

  assign head              = mem[rd_ptr];
  assign rsp_valid         = (count != '0);
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_id        = head.id;
  assign bus.rsp_root      = head.root;
  assign bus.rsp_remainder = head.rem;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      RUN:   if (flush) state_d = DRAIN;
      DRAIN: if (outstanding == '0) state_d = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_d    = flush ? HOLD : RUN;
      end
      HOLD:  if (!flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end
endmodule

// File: tb/tb_sqrt_scheduler.sv
// Randomized scoreboard bench for sqrt_scheduler: a behavioural square_root
// pipeline, a round-robin/credit reference model and directed corner cases.
module tb_sqrt_scheduler;
  localparam int DW    = 32;
  localparam int NR    = 4;
  localparam int LAT   = 16;
  localparam int DEPTH = 8;

  typedef struct {
    int          id;
    logic [31:0] root;
    logic [31:0] rem;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          sq_i_valid, sq_o_valid, flush, flush_done;
  logic [DW-1:0] sq_radicand, sq_root, sq_remainder;
  logic [1:0]    err;
  logic          inject, suppress;

  int   checks = 0, errors = 0;
  int   credit = 0, rr = 0, cyc = 0, last_pop_cyc = 0, n_issued = 0, edges = 0;
  bit   allow = 1'b1;
  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  sqrt_scheduler_if #(.DATAWIDTH(DW), .NUM_REQ(NR)) bus ();

  sqrt_scheduler #(.DATAWIDTH(DW), .NUM_REQ(NR), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus),
    .sq_i_valid(sq_i_valid), .sq_radicand(sq_radicand),
    .sq_o_valid(sq_o_valid), .sq_root(sq_root), .sq_remainder(sq_remainder),
    .flush(flush), .flush_done(flush_done), .err(err)
  );

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    longint lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else                          hi = mid - 1;
    end
    return lo[31:0];
  endfunction

  // Behavioural square_root: unresettable fixed-latency pipe, seeded with garbage.
  logic [LAT-1:0] pv = LAT'('hA5C3);
  logic [DW-1:0]  prad [LAT];
  always @(posedge i_clk) begin
    pv      <= {pv[LAT-2:0], sq_i_valid};
    prad[0] <= sq_radicand;
    for (int i = 1; i < LAT; i++) prad[i] <= prad[i-1];
  end
  assign sq_o_valid   = (pv[LAT-1] & ~suppress) | inject;
  assign sq_root      = isqrt(prad[LAT-1]);
  assign sq_remainder = prad[LAT-1] - sq_root * sq_root;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model + monitor: predicts each grant, queues its result, checks pops.
  always @(negedge i_clk) begin
    int            k;
    bit            found;
    logic [NR-1:0] exp_ready;
    logic [DW-1:0] rad;
    exp_t          e;
    cyc++;
    if (i_rst) begin
      sb.delete();
      credit = 0;
      rr     = 0;
    end else begin
      found     = 1'b0;
      exp_ready = '0;
      k         = 0;
      rad       = '0;
      if (allow && edges >= LAT && credit < DEPTH)
        for (int i = 0; i < NR; i++)
          if (!found && bus.req_valid[(rr + i) % NR]) begin
            found = 1'b1;
            k     = (rr + i) % NR;
          end
      if (found) exp_ready[k] = 1'b1;
      check("req_ready", bus.req_ready, exp_ready);
      check("sq_i_valid", sq_i_valid, found);
      if (found) begin
        rad = bus.req_radicand[k*DW +: DW];
        check("sq_radicand", sq_radicand, rad);
        e.id   = k;
        e.root = isqrt(rad);
        e.rem  = rad - e.root * e.root;
        sb.push_back(e);
        rr = (k + 1) % NR;
        credit++;
        n_issued++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d with nothing outstanding", bus.rsp_id);
        end else begin
          e = sb.pop_front();
          check("rsp_id", bus.rsp_id, e.id);
          check("rsp_root", bus.rsp_root, e.root);
          check("rsp_remainder", bus.rsp_remainder, e.rem);
        end
        credit--;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic randomize_radicands();
    for (int r = 0; r < NR; r++) bus.req_radicand[r*DW +: DW] = $urandom();
  endtask

  task automatic drain(input int limit);
    int n;
    @(posedge i_clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge i_clk); #1;
      n++;
    end
    check("drain_complete", sb.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_sq_i_valid", sq_i_valid, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_err", err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, base, bad;
    bit got;
    bus.req_valid    = '1;
    bus.req_radicand = '0;
    bus.rsp_ready    = 1'b1;
    flush = 1'b0; inject = 1'b0; suppress = 1'b0; i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); #1;
    check_reset_outputs();

    // Guard window, then a single 144 request.
    bus.req_valid            = 4'b0001;
    bus.req_radicand[0 +: DW] = 32'd144;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    n = 0; got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge i_clk); #1;
      if (bus.req_ready[0]) got = 1'b1;
      else                  n++;
    end
    check("first_grant_delay", n, LAT);
    @(posedge i_clk); #1;
    bus.req_valid = '0;
    for (int c = 0; c < LAT + 10 && !bus.rsp_valid; c++) begin
      @(negedge i_clk); #1;
    end
    check("t1_rsp_valid", bus.rsp_valid, 1);
    check("t1_rsp_id", bus.rsp_id, 0);
    check("t1_root_144", bus.rsp_root, 12);
    check("t1_rem_144", bus.rsp_remainder, 0);
    drain(50);

    // All requesters busy: round-robin order, radicand 17 first.
    @(posedge i_clk); #1;
    bus.req_radicand = {NR{32'd17}};
    bus.req_valid    = '1;
    for (int c = 0; c < LAT + 10 && !bus.rsp_valid; c++) begin
      @(negedge i_clk); #1;
    end
    check("t2_root_17", bus.rsp_root, 4);
    check("t2_rem_17", bus.rsp_remainder, 1);
    for (int c = 0; c < 40; c++) begin
      @(posedge i_clk); #1;
      randomize_radicands();
    end
    drain(100);

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      @(posedge i_clk); #1;
      bus.req_valid = NR'($urandom());
      randomize_radicands();
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
    end
    drain(200);

    // Credit limit: exactly DEPTH issues, then one more per pop.
    @(posedge i_clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk); #1;
      if (bus.req_valid[0] && bus.req_ready[0]) n++;
    end
    check("credit_issues", n, DEPTH);
    check("credit_stall_ready", bus.req_ready, 0);
    @(posedge i_clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    bus.rsp_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk); #1;
      if (bus.req_valid[0] && bus.req_ready[0]) n++;
    end
    check("credit_one_more", n, 1);
    drain(100);

    // Flush with five results in flight.
    @(posedge i_clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    randomize_radicands();
    base = n_issued;
    for (int c = 0; c < 40 && (n_issued - base) < 5; c++) begin
      @(negedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    flush = 1'b1;
    allow = 1'b0;
    for (int c = 0; c < 60 && !flush_done; c++) begin
      @(negedge i_clk); #1;
    end
    check("flush_done_seen", flush_done, 1);
    check("flush_done_gap", cyc - last_pop_cyc, 2);
    check("flush_drained", sb.size(), 0);
    @(posedge i_clk); #1;
    @(negedge i_clk); #1;
    check("flush_done_width", flush_done, 0);
    @(posedge i_clk); #1;
    flush = 1'b0;
    @(negedge i_clk); #1;
    check("hold_no_grant", sq_i_valid, 0);
    @(posedge i_clk); #1;
    allow = 1'b1;
    @(negedge i_clk); #1;
    check("grant_resumes", sq_i_valid, 1);
    drain(100);

    // Unexpected result pulse.
    @(negedge i_clk); #1;
    inject = 1'b1;
    @(posedge i_clk); #1;
    inject = 1'b0;
    @(negedge i_clk); #1;
    check("spur_err", err, 2'b01);
    check("spur_fifo_empty", bus.rsp_valid, 0);
    repeat (3) @(negedge i_clk);
    #1;
    check("spur_fifo_empty_later", bus.rsp_valid, 0);

    // Missing result: one issue, its sq_o_valid suppressed.
    @(posedge i_clk); #1;
    bus.req_valid = 4'b0001;
    bus.req_radicand[0 +: DW] = $urandom();
    @(posedge i_clk); #1;
    bus.req_valid = '0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge i_clk); #1;
      if (pv[LAT-1]) begin
        suppress = 1'b1;
        got      = 1'b1;
        if (sb.size() != 0) void'(sb.pop_front());
        credit--;
      end
    end
    check("miss_result_arrived", got, 1);
    @(posedge i_clk); #1;
    suppress = 1'b0;
    @(negedge i_clk); #1;
    check("miss_err", err, 2'b11);
    check("miss_fifo_empty", bus.rsp_valid, 0);
    @(posedge i_clk); #1;
    flush = 1'b1;
    allow = 1'b0;
    n = 0;
    while (n < 6) begin
      @(negedge i_clk); #1;
      n++;
      if (flush_done) break;
    end
    check("miss_credit_returned", n, 3);
    @(posedge i_clk); #1;
    flush = 1'b0;
    @(posedge i_clk); #1;
    allow = 1'b1;

    // Reset with six results outstanding; stale outputs must be ignored.
    @(posedge i_clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    base = n_issued;
    for (int c = 0; c < 30 && (n_issued - base) < 6; c++) begin
      @(negedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    bus.req_valid = '0;
    @(posedge i_clk); #1;
    bus.req_valid = '1;
    i_rst = 1'b1;
    @(negedge i_clk); #1;
    check_reset_outputs();
    @(posedge i_clk); #1;
    i_rst         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < LAT + 6; c++) begin
      @(negedge i_clk); #1;
      if (bus.rsp_valid) bad++;
    end
    check("stale_rsp_ignored", bad, 0);
    check("stale_err_clear", err, 0);

    // Normal operation after reset.
    for (int c = 0; c < 30; c++) begin
      @(posedge i_clk); #1;
      bus.req_valid = '1;
      randomize_radicands();
    end
    drain(100);
    check("final_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
